// File: rtl/video_line_output_pkg.sv
// Shared video definitions for the pixel-fetch stage and the VGA timing generator.
//   - default line geometry (active width, line-buffer address width, palette index width)
//   - RGB444 field positions within a 12-bit colour word
//   - pixel pipeline latency that the timing generator compensates for
package video_line_output_pkg;

    localparam int VID_LINE_WIDTH = 640;
    localparam int VID_ADDR_W     = 10;
    localparam int VID_IDX_W      = 8;

    localparam int RGB_W    = 12;
    localparam int RGB_R_HI = 11;
    localparam int RGB_R_LO = 8;
    localparam int RGB_G_HI = 7;
    localparam int RGB_G_LO = 4;
    localparam int RGB_B_HI = 3;
    localparam int RGB_B_LO = 0;

    // Cycles from rd_addr presentation to colour on palette_rgb_data.
    localparam int PIXEL_LATENCY = 2;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    function automatic rgb444_t rgb444_unpack(input logic [RGB_W-1:0] raw);
        rgb444_t c;
        c.r = raw[RGB_R_HI:RGB_R_LO];
        c.g = raw[RGB_G_HI:RGB_G_LO];
        c.b = raw[RGB_B_HI:RGB_B_LO];
        return c;
    endfunction

endpackage

// File: rtl/video_line_output_dp_ram.sv
// video_dp_ram: simple dual-port RAM, one write port and one registered read port.
// A read of the entry being written on the same edge returns the old contents.
// Only the read data register is reset; the array itself is not.
// Ports:
//   clk, rst             clock, asynchronous active-high reset (read register only)
//   wr_en_i/addr_i/data_i write port; addresses >= DEPTH are dropped
//   rd_addr_i            read address, sampled every clk
//   rd_data_o            registered read data
module video_dp_ram #(
    parameter int DEPTH  = 640,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic              wr_ok;

    assign wr_ok = wr_en_i && ({1'b0, wr_addr_i} < DEPTH_L);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/video_line_output.sv
// video_line_output: pixel-fetch stage feeding the VGA timing generator.
// Streams the front line bank through the palette, one pixel per clk, while the
// composer fills the back bank. Colour for rd_addr=k appears two cycles later.
// Ports:
//   clk, rst             pixel clock, asynchronous active-high reset
//   next_line            last clock of a line: swap banks, restart read address
//   next_frame           registered to frame_start
//   lb_wr_en/addr/data   composer writes into the back bank
//   pal_wr_en/addr/data  palette entry writes, RGB444
//   palette_rgb_data     colour for the pixel slot two cycles earlier
//   back_bank            bank currently writable by the composer
//   line_start           registered next_line
//   frame_start          registered next_frame
module video_line_output
    import video_line_output_pkg::*;
#(
    parameter int LINE_WIDTH = VID_LINE_WIDTH,
    parameter int ADDR_W     = VID_ADDR_W,
    parameter int IDX_W      = VID_IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              next_line,
    input  logic              next_frame,
    input  logic              lb_wr_en,
    input  logic [ADDR_W-1:0] lb_wr_addr,
    input  logic [IDX_W-1:0]  lb_wr_data,
    input  logic              pal_wr_en,
    input  logic [IDX_W-1:0]  pal_wr_addr,
    input  logic [RGB_W-1:0]  pal_wr_data,
    output logic [RGB_W-1:0]  palette_rgb_data,
    output logic              back_bank,
    output logic              line_start,
    output logic              frame_start
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_WIDTH - 1);
    localparam logic [ADDR_W:0]   WIDTH_L   = (ADDR_W+1)'(LINE_WIDTH);

    logic              front_bank_q, front_bank_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_bank_q;
    logic              line_start_q;
    logic              frame_start_q;

    logic              lb_wr_ok;
    logic              wr_bank0, wr_bank1;
    logic [IDX_W-1:0]  idx_bank0, idx_bank1;
    logic [IDX_W-1:0]  idx_r;

    always_comb begin
        front_bank_d = front_bank_q;
        rd_addr_d    = rd_addr_q;
        if (next_line) begin
            front_bank_d = ~front_bank_q;
            rd_addr_d    = '0;
        end else if (rd_addr_q != LAST_ADDR) begin
            rd_addr_d = rd_addr_q + 1'b1;
        end
    end

    // rd_bank_q remembers which bank was read on the previous edge, so the
    // stage-1 mux stays on the old front bank for the last pixel of a line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            front_bank_q  <= 1'b0;
            rd_addr_q     <= '0;
            rd_bank_q     <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            front_bank_q  <= front_bank_d;
            rd_addr_q     <= rd_addr_d;
            rd_bank_q     <= front_bank_q;
            line_start_q  <= next_line;
            frame_start_q <= next_frame;
        end
    end

    // Writes target the back bank as seen before the edge, so a write on a
    // swap edge lands in the bank that is about to become front.
    assign lb_wr_ok = lb_wr_en && ({1'b0, lb_wr_addr} < WIDTH_L);
    assign wr_bank0 = lb_wr_ok && front_bank_q;
    assign wr_bank1 = lb_wr_ok && !front_bank_q;

    video_dp_ram #(
        .DEPTH  (LINE_WIDTH),
        .ADDR_W (ADDR_W),
        .DATA_W (IDX_W)
    ) u_bank0 (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_bank0),
        .wr_addr_i (lb_wr_addr),
        .wr_data_i (lb_wr_data),
        .rd_addr_i (rd_addr_q),
        .rd_data_o (idx_bank0)
    );

    video_dp_ram #(
        .DEPTH  (LINE_WIDTH),
        .ADDR_W (ADDR_W),
        .DATA_W (IDX_W)
    ) u_bank1 (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_bank1),
        .wr_addr_i (lb_wr_addr),
        .wr_data_i (lb_wr_data),
        .rd_addr_i (rd_addr_q),
        .rd_data_o (idx_bank1)
    );

    assign idx_r = rd_bank_q ? idx_bank1 : idx_bank0;

    video_dp_ram #(
        .DEPTH  (1 << IDX_W),
        .ADDR_W (IDX_W),
        .DATA_W (RGB_W)
    ) u_palette (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (pal_wr_en),
        .wr_addr_i (pal_wr_addr),
        .wr_data_i (pal_wr_data),
        .rd_addr_i (idx_r),
        .rd_data_o (palette_rgb_data)
    );

    assign back_bank   = ~front_bank_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_line_output.sv
module tb_video_line_output;

    logic        clk;
    logic        rst;
    logic        next_line;
    logic        next_frame;
    logic        lb_wr_en;
    logic [9:0]  lb_wr_addr;
    logic [7:0]  lb_wr_data;
    logic        pal_wr_en;
    logic [7:0]  pal_wr_addr;
    logic [11:0] pal_wr_data;
    logic [11:0] palette_rgb_data;
    logic        back_bank;
    logic        line_start;
    logic        frame_start;

    int total = 0;
    int bad   = 0;

    video_line_output dut (
        .clk              (clk),
        .rst              (rst),
        .next_line        (next_line),
        .next_frame       (next_frame),
        .lb_wr_en         (lb_wr_en),
        .lb_wr_addr       (lb_wr_addr),
        .lb_wr_data       (lb_wr_data),
        .pal_wr_en        (pal_wr_en),
        .pal_wr_addr      (pal_wr_addr),
        .pal_wr_data      (pal_wr_data),
        .palette_rgb_data (palette_rgb_data),
        .back_bank        (back_bank),
        .line_start       (line_start),
        .frame_start      (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory contents as arrays with "known" flags, plus the
    // pixel slot bookkeeping. A slot's colour is the palette entry as it stood
    // when the slot's index was looked up, which is before any same-edge write.
    logic [7:0]  bank_m [2][640];
    bit          bank_v [2][640];
    logic [11:0] pal_m  [256];
    bit          pal_v  [256];
    bit          front_m;
    int          rd_m;
    logic [7:0]  idx_m;
    bit          idx_v;
    logic [11:0] rgb_m;
    bit          rgb_v;
    bit          ls_m, fs_m;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            front_m = 1'b0;
            rd_m    = 0;
            idx_m   = 8'h00;
            idx_v   = 1'b1;
            rgb_m   = 12'h000;
            rgb_v   = 1'b1;
            ls_m    = 1'b0;
            fs_m    = 1'b0;
        end else begin
            rgb_v = idx_v && pal_v[idx_m];
            rgb_m = pal_m[idx_m];
            idx_v = bank_v[front_m][rd_m];
            idx_m = bank_m[front_m][rd_m];
            if (pal_wr_en) begin
                pal_m[pal_wr_addr] = pal_wr_data;
                pal_v[pal_wr_addr] = 1'b1;
            end
            if (lb_wr_en && int'(lb_wr_addr) < 640) begin
                bank_m[!front_m][lb_wr_addr] = lb_wr_data;
                bank_v[!front_m][lb_wr_addr] = 1'b1;
            end
            ls_m = next_line;
            fs_m = next_frame;
            if (next_line) begin
                front_m = !front_m;
                rd_m    = 0;
            end else if (rd_m < 639) begin
                rd_m = rd_m + 1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("model_back_bank", {11'd0, back_bank}, {11'd0, !front_m});
        chk("model_line_start", {11'd0, line_start}, {11'd0, ls_m});
        chk("model_frame_start", {11'd0, frame_start}, {11'd0, fs_m});
        if (rgb_v) chk("model_rgb", palette_rgb_data, rgb_m);
    end

    task automatic idle_inputs();
        next_line   = 1'b0;
        next_frame  = 1'b0;
        lb_wr_en    = 1'b0;
        lb_wr_addr  = 10'd0;
        lb_wr_data  = 8'd0;
        pal_wr_en   = 1'b0;
        pal_wr_addr = 8'd0;
        pal_wr_data = 12'd0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        chk("reset_rgb", palette_rgb_data, 12'h000);
        chk("reset_back_bank", {11'd0, back_bank}, 12'd1);
        chk("reset_line_start", {11'd0, line_start}, 12'd0);
        rst = 1'b0;

        // Palette ramp and index ramp into back bank 1.
        for (int x = 0; x < 640; x++) begin
            lb_wr_en    = 1'b1;
            lb_wr_addr  = 10'(x);
            lb_wr_data  = 8'(x);
            pal_wr_en   = (x < 256);
            pal_wr_addr = 8'(x);
            pal_wr_data = {4'(x), ~4'(x), 4'h5};
            @(negedge clk);
        end
        idle_inputs();
        next_line = 1'b1;
        @(negedge clk);
        next_line = 1'b0;
        chk("swap1_back_bank", {11'd0, back_bank}, 12'd0);
        chk("swap1_line_start", {11'd0, line_start}, 12'd1);

        // Line 1: stream ramp, fill bank 0 with idx 7, out-of-range writes, palette RAW.
        for (int i = 0; i < 700; i++) begin
            if (i == 1)   chk("line_start_one_cycle", {11'd0, line_start}, 12'd0);
            if (i == 2)   chk("pixel0", palette_rgb_data, 12'h0F5);
            if (i == 7)   chk("pal_raw_old", palette_rgb_data, 12'h5A5);
            if (i == 263) chk("pal_raw_new", palette_rgb_data, 12'hABC);
            if (i == 302) chk("pixel300", palette_rgb_data, 12'hC35);
            if (i == 690) chk("hold_last", palette_rgb_data, 12'hF05);
            lb_wr_en   = (i < 642);
            lb_wr_addr = (i < 640) ? 10'(i) : ((i == 640) ? 10'd640 : 10'd1023);
            lb_wr_data = (i < 640) ? 8'h07 : 8'hFF;
            pal_wr_en   = (i == 6);
            pal_wr_addr = 8'd5;
            pal_wr_data = 12'hABC;
            @(negedge clk);
        end
        idle_inputs();
        next_line = 1'b1;
        @(negedge clk);
        next_line = 1'b0;
        chk("swap2_back_bank", {11'd0, back_bank}, 12'd1);

        // Line 2: constant colour, then reset at rd_addr=200.
        for (int i = 0; i < 200; i++) begin
            if (i == 2)   chk("const_pixel0", palette_rgb_data, 12'h785);
            if (i == 150) chk("const_pixel148", palette_rgb_data, 12'h785);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk("midline_rst_rgb", palette_rgb_data, 12'h000);
        chk("midline_rst_back_bank", {11'd0, back_bank}, 12'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 10) chk("post_rst_bank0", palette_rgb_data, 12'h785);
            @(negedge clk);
        end

        // Lone next_frame: no swap.
        next_frame = 1'b1;
        @(negedge clk);
        next_frame = 1'b0;
        chk("lone_frame_start", {11'd0, frame_start}, 12'd1);
        chk("lone_frame_no_swap", {11'd0, back_bank}, 12'd1);
        chk("lone_frame_no_line", {11'd0, line_start}, 12'd0);
        @(negedge clk);
        chk("frame_start_one_cycle", {11'd0, frame_start}, 12'd0);

        // Frame start with line swap back to the ramp bank.
        next_line  = 1'b1;
        next_frame = 1'b1;
        @(negedge clk);
        next_line  = 1'b0;
        next_frame = 1'b0;
        chk("frame_swap_back_bank", {11'd0, back_bank}, 12'd0);
        chk("frame_swap_frame_start", {11'd0, frame_start}, 12'd1);
        for (int i = 0; i < 310; i++) begin
            if (i == 7)   chk("realign_pixel5", palette_rgb_data, 12'hABC);
            if (i == 302) chk("realign_pixel300", palette_rgb_data, 12'hC35);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
